// File: rtl/apb_arbiter_if.sv
// APB3 bus bundle shared by the two requester ports and the slave port of apb_arbiter.
// The master modport is the side that drives the address phase; slave answers it.
interface apb_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_WIDTH     = 4
);
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [0:0]               psel;
  logic                     penable;
  logic                     pwrite;
  logic [BUS_WIDTH*8-1:0]   pwdata;
  logic                     pready;
  logic [BUS_WIDTH*8-1:0]   prdata;
  logic                     pslverror;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverror
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverror
  );
endinterface

// File: rtl/apb_arbiter.sv
// Two-requester round-robin APB3 arbiter onto one shared slave (IDLE/SETUP/ACCESS/RESP).
// Optional ACCESS timeout with error response when APB_ARBITER_TIMEOUT_EN is defined.
module apb_arbiter #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  apb_arbiter_if.slave    s0_apb,
  apb_arbiter_if.slave    s1_apb,
  apb_arbiter_if.master   m_apb
);

  localparam int unsigned DataWidth = BUS_WIDTH * 8;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [DataWidth-1:0]     pwdata_q, pwdata_d;
  logic [DataWidth-1:0]     prdata_q, prdata_d;
  logic                     pslverror_q, pslverror_d;

  logic req0, req1, grant1, timeout;

  assign req0 = s0_apb.psel[0];
  assign req1 = s1_apb.psel[0];
  // last_q=1 means s1 was granted last; reset value gives s0 the first tie.
  assign grant1 = req1 & (~req0 | ~last_q);

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = (state_q == StAccess) ? cnt_q + 1'b1 : '0;
    timeout = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    prdata_d    = prdata_q;
    pslverror_d = pslverror_q;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d  = grant1;
          last_d   = grant1;
          paddr_d  = grant1 ? s1_apb.paddr  : s0_apb.paddr;
          pwrite_d = grant1 ? s1_apb.pwrite : s0_apb.pwrite;
          pwdata_d = grant1 ? s1_apb.pwdata : s0_apb.pwdata;
          state_d  = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (m_apb.pready) begin
          prdata_d    = m_apb.prdata;
          pslverror_d = m_apb.pslverror;
          state_d     = StResp;
        end else if (timeout) begin
          prdata_d    = '0;
          pslverror_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      prdata_q    <= '0;
      pslverror_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      prdata_q    <= prdata_d;
      pslverror_q <= pslverror_d;
    end
  end

  logic resp0, resp1;

  assign resp0 = (state_q == StResp) && !owner_q;
  assign resp1 = (state_q == StResp) && owner_q;

  assign m_apb.paddr   = paddr_q;
  assign m_apb.psel    = (state_q == StSetup) || (state_q == StAccess);
  assign m_apb.penable = (state_q == StAccess);
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pwdata  = pwdata_q;

  assign s0_apb.pready    = resp0;
  assign s0_apb.prdata    = resp0 ? prdata_q : '0;
  assign s0_apb.pslverror = resp0 & pslverror_q;

  assign s1_apb.pready    = resp1;
  assign s1_apb.prdata    = resp1 ? prdata_q : '0;
  assign s1_apb.pslverror = resp1 & pslverror_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for latency, ordering, wait states, errors, reset and timeout.
module tb_apb_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_arbiter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) s0_apb ();
  apb_arbiter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) s1_apb ();
  apb_arbiter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) m_apb ();

  apb_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s0_apb(s0_apb),
    .s1_apb(s1_apb),
    .m_apb (m_apb)
  );

  // requester and slave drive state
  logic        r_psel  [2];
  logic [31:0] r_addr  [2];
  logic        r_write [2];
  logic [31:0] r_wdata [2];
  int          reps    [2];
  bit          rearm   [2];
  logic        sl_pready;
  logic [31:0] sl_rdata;
  logic        sl_err;
  bit          sl_never;
  int          wait_n;
  int          acc_cnt, pen_run, sel_run;

  assign s0_apb.psel    = r_psel[0];
  assign s0_apb.penable = r_psel[0];
  assign s0_apb.paddr   = r_addr[0];
  assign s0_apb.pwrite  = r_write[0];
  assign s0_apb.pwdata  = r_wdata[0];
  assign s1_apb.psel    = r_psel[1];
  assign s1_apb.penable = r_psel[1];
  assign s1_apb.paddr   = r_addr[1];
  assign s1_apb.pwrite  = r_write[1];
  assign s1_apb.pwdata  = r_wdata[1];
  assign m_apb.pready    = sl_pready;
  assign m_apb.prdata    = sl_rdata;
  assign m_apb.pslverror = sl_err;

  logic [1:0]  s_pready;
  logic [31:0] s_prdata [2];
  logic [1:0]  s_perr;
  assign s_pready    = {s1_apb.pready, s0_apb.pready};
  assign s_perr      = {s1_apb.pslverror, s0_apb.pslverror};
  assign s_prdata[0] = s0_apb.prdata;
  assign s_prdata[1] = s1_apb.prdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // completion log
  int          done_who[$];
  int unsigned done_cyc[$];
  logic [31:0] done_rdata[$];
  logic        done_err[$];
  int          pen_runs[$];
  int          sel_runs[$];
  int unsigned rdy_q[$];

  // Slave and requester behaviour, acting just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      acc_cnt = 0; pen_run = 0; sel_run = 0; sl_pready = 1'b0;
    end else begin
      if (m_apb.psel[0] && m_apb.penable) begin
        acc_cnt++;
        pen_run++;
        sl_pready = !sl_never && (acc_cnt > wait_n);
        if (sl_pready) rdy_q.push_back(cyc);
      end else begin
        acc_cnt = 0;
        sl_pready = cyc[0];  // noise outside ACCESS must be ignored
      end
      if (m_apb.psel[0]) sel_run++;
      for (int k = 0; k < 2; k++) begin
        if (s_pready[k]) begin
          done_who.push_back(k);
          done_cyc.push_back(cyc);
          done_rdata.push_back(s_prdata[k]);
          done_err.push_back(s_perr[k]);
          pen_runs.push_back(pen_run);
          sel_runs.push_back(sel_run);
          pen_run = 0;
          sel_run = 0;
          r_psel[k] = 1'b0;
          if (reps[k] > 0) begin
            reps[k]--;
            rearm[k] = 1'b1;
          end
        end else if (rearm[k]) begin
          r_psel[k] = 1'b1;
          rearm[k]  = 1'b0;
        end
      end
    end
  end

  // Reference model: one transaction at a time, tracked by age since grant.
  bit          mb_busy, mb_done, mb_write, mb_err;
  int          mb_owner, mb_prio, mb_age;
  logic [31:0] mb_addr, mb_wdata, mb_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_busy = 0; mb_done = 0; mb_prio = 0; mb_age = 0; mb_owner = 0;
      mb_addr = '0; mb_wdata = '0; mb_write = 0; mb_rdata = '0; mb_err = 0;
    end else if (!mb_busy) begin
      if (r_psel[0] || r_psel[1]) begin
        mb_owner = (r_psel[0] && r_psel[1]) ? mb_prio : (r_psel[0] ? 0 : 1);
        mb_prio  = 1 - mb_owner;
        mb_addr  = r_addr[mb_owner];
        mb_write = r_write[mb_owner];
        mb_wdata = r_wdata[mb_owner];
        mb_busy  = 1; mb_done = 0; mb_age = 1;
      end
    end else if (mb_done) begin
      mb_busy = 0;
    end else if (mb_age >= 2 && sl_pready) begin
      mb_done = 1; mb_rdata = sl_rdata; mb_err = sl_err;
`ifdef APB_ARBITER_TIMEOUT_EN
    end else if (mb_age >= 2 && mb_age - 1 == int'(TO)) begin
      mb_done = 1; mb_rdata = '0; mb_err = 1;
`endif
    end else begin
      mb_age++;
    end
  end

  always @(negedge clk) begin
    bit act, rdy;
    act = mb_busy && !mb_done;
    chk("m_psel", m_apb.psel, act);
    chk("m_penable", m_apb.penable, act && mb_age >= 2);
    chk("m_paddr", m_apb.paddr, mb_addr);
    chk("m_pwrite", m_apb.pwrite, mb_write);
    chk("m_pwdata", m_apb.pwdata, mb_wdata);
    for (int k = 0; k < 2; k++) begin
      rdy = mb_busy && mb_done && mb_owner == k;
      chk($sformatf("s%0d_pready", k), s_pready[k], rdy);
      chk($sformatf("s%0d_prdata", k), s_prdata[k], rdy ? mb_rdata : 32'h0);
      chk($sformatf("s%0d_pslverror", k), s_perr[k], rdy && mb_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [31:0] d);
    r_addr[k]  = a;
    r_write[k] = w;
    r_wdata[k] = d;
    r_psel[k]  = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_who.size() < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("done_count", done_who.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, rb;
    int unsigned c0;
    for (int k = 0; k < 2; k++) begin
      r_psel[k] = 0; r_addr[k] = '0; r_write[k] = 0; r_wdata[k] = '0;
      reps[k] = 0; rearm[k] = 0;
    end
    sl_pready = 0; sl_rdata = '0; sl_err = 0; sl_never = 0; wait_n = 0;
    acc_cnt = 0; pen_run = 0; sel_run = 0;
    rst = 1'b1;
    tick(3);
    chk("rst_m_psel", m_apb.psel, 0);
    chk("rst_m_paddr", m_apb.paddr, 0);
    chk("rst_s0_pready", s0_apb.pready, 0);
    rst = 1'b0;
    tick(2);

    // single read
    b = done_who.size();
    sl_rdata = 32'hDEADBEEF; sl_err = 0; wait_n = 0;
    issue(0, 32'h10, 1'b0, 32'h0);
    c0 = cyc;
    wait_done(b + 1, 20);
    chk("t1_who", done_who[b], 0);
    chk("t1_rdata", done_rdata[b], 32'hDEADBEEF);
    chk("t1_latency", done_cyc[b] - c0 + 1, 4);
    chk("t1_psel_cycles", sel_runs[b], 2);
    chk("t1_paddr", m_apb.paddr, 32'h10);

    // fresh reset, then simultaneous repeated requests
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    b = done_who.size();
    sl_rdata = 32'h11112222;
    reps[0] = 1; reps[1] = 1;
    issue(0, 32'h100, 1'b0, 32'h0);
    issue(1, 32'h200, 1'b0, 32'h0);
    wait_done(b + 4, 60);
    chk("t2_order0", done_who[b], 0);
    chk("t2_order1", done_who[b + 1], 1);
    chk("t2_order2", done_who[b + 2], 0);
    chk("t2_order3", done_who[b + 3], 1);
    tick(2);

    // wait states, s1 arrives one cycle later and must be held off
    b = done_who.size();
    rb = rdy_q.size();
    wait_n = 5; sl_rdata = 32'h33334444;
    issue(0, 32'h30, 1'b0, 32'h0);
    tick(1);
    issue(1, 32'h34, 1'b0, 32'h0);
    wait_done(b + 2, 60);
    chk("t3_order0", done_who[b], 0);
    chk("t3_order1", done_who[b + 1], 1);
    chk("t3_penable_cycles", pen_runs[b], 6);
    chk("t3_resp_after_ready", done_cyc[b] - rdy_q[rb], 1);
    chk("t3_s1_gap", done_cyc[b + 1] - done_cyc[b], 9);
    wait_n = 0;
    tick(2);

    // write with slave error
    b = done_who.size();
    sl_err = 1; sl_rdata = 32'h0BADF00D;
    issue(1, 32'h20, 1'b1, 32'hA5A5A5A5);
    wait_done(b + 1, 20);
    chk("t4_who", done_who[b], 1);
    chk("t4_err", done_err[b], 1);
    chk("t4_rdata", done_rdata[b], 32'h0BADF00D);
    chk("t4_pwrite", m_apb.pwrite, 1);
    chk("t4_pwdata", m_apb.pwdata, 32'hA5A5A5A5);
    chk("t4_paddr", m_apb.paddr, 32'h20);
    sl_err = 0;
    tick(2);

    // reset in the middle of an s0 ACCESS
    b = done_who.size();
    wait_n = 1000;
    issue(0, 32'h50, 1'b1, 32'h12345678);
    for (int n = 0; n < 20 && !m_apb.penable; n++) tick(1);
    tick(2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_m_psel", m_apb.psel, 0);
    chk("t5_m_penable", m_apb.penable, 0);
    chk("t5_m_paddr", m_apb.paddr, 0);
    chk("t5_m_pwrite", m_apb.pwrite, 0);
    chk("t5_m_pwdata", m_apb.pwdata, 0);
    chk("t5_s0_pready", s0_apb.pready, 0);
    chk("t5_no_resp", done_who.size(), b);
    wait_n = 0; sl_rdata = 32'h55556666;
    issue(1, 32'h60, 1'b0, 32'h0);
    tick(2);
    rst = 1'b0;
    wait_done(b + 2, 30);
    chk("t5_order0", done_who[b], 0);
    chk("t5_order1", done_who[b + 1], 1);
    tick(2);

`ifdef APB_ARBITER_TIMEOUT_EN
    // slave never answers
    b = done_who.size();
    sl_never = 1; sl_rdata = 32'hFFFFFFFF;
    issue(0, 32'h40, 1'b0, 32'h0);
    wait_done(b + 1, 40);
    chk("t6_err", done_err[b], 1);
    chk("t6_rdata", done_rdata[b], 0);
    chk("t6_penable_cycles", pen_runs[b], 8);
    sl_never = 0;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
